// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and field widths for the i2c_mmaster arbiter
package i2c_arb_pkg;

  localparam int DEVADR_W = 7;
  localparam int REGADR_W = 8;
  localparam int DATNUM_W = 16;
  localparam int DATA_W   = 8;
  localparam int TMO_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_mmaster_arb_if.sv
// rtl/i2c_mmaster_arb_if.sv - command/status bundle between the arbiter and the shared i2c_mmaster
interface i2c_mmaster_arb_if;
  import i2c_arb_pkg::*;

  logic                m_enable_o;
  logic                m_rw_o;
  logic                m_ur_o;
  logic [DEVADR_W-1:0] m_devadr_o;
  logic [REGADR_W-1:0] m_regadr_o;
  logic [DATNUM_W-1:0] m_datnum_o;
  logic [DATA_W-1:0]   m_dat_o;
  logic                m_reset_o;
  logic                m_busy_i;
  logic                m_dvalid_i;
  logic                m_newdat_i;
  logic [DATA_W-1:0]   m_dat_i;

  // arbiter side
  modport master (
    output m_enable_o, m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o, m_dat_o, m_reset_o,
    input  m_busy_i, m_dvalid_i, m_newdat_i, m_dat_i
  );

  // i2c_mmaster side
  modport slave (
    input  m_enable_o, m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o, m_dat_o, m_reset_o,
    output m_busy_i, m_dvalid_i, m_newdat_i, m_dat_i
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr, wrapping
module i2c_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        gnt[(int'(ptr) + i) % NREQ] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_mmaster_arb.sv
// rtl/i2c_mmaster_arb.sv - round-robin arbiter/sequencer sharing one i2c_mmaster among NREQ requesters
// Optional watchdog: I2C_ARB_TIMEOUT_EN
module i2c_mmaster_arb
  import i2c_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int TMO_CYCLES = 65535
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          rw_i,
  input  logic [NREQ-1:0]          ur_i,
  input  logic [DEVADR_W*NREQ-1:0] devadr_i,
  input  logic [REGADR_W*NREQ-1:0] regadr_i,
  input  logic [DATNUM_W*NREQ-1:0] datnum_i,
  input  logic [DATA_W*NREQ-1:0]   wdat_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          done_o,
  output logic [NREQ-1:0]          err_o,
  output logic [NREQ-1:0]          newdat_o,
  output logic [NREQ-1:0]          dvalid_o,
  output logic [DATA_W-1:0]        rdat_o,
  i2c_mmaster_arb_if.master        m
);

  arb_state_e          state, nxt;
  logic [1:0]          ptr, ptr_nxt;
  logic [NREQ-1:0]     gnt_q, pick;
  logic                pick_any;
  logic                tmo_hit, tmo_done;
  logic                sel_rw, sel_ur;
  logic [DEVADR_W-1:0] sel_dev;
  logic [REGADR_W-1:0] sel_reg;
  logic [DATNUM_W-1:0] sel_dn;
  logic [DATA_W-1:0]   sel_dat;

  i2c_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick),
    .any (pick_any)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;
  logic             in_txn;

  assign in_txn   = (state == LAUNCH) || (state == RUN);
  assign tmo_hit  = in_txn && (tmo_cnt == TMO_LAST);
  assign tmo_done = tmo_flag;

  // tmo_flag marks a DONE entered by the watchdog rather than by the master
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_cnt <= in_txn ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit)
        tmo_flag <= 1'b1;
      else if (state == DONE)
        tmo_flag <= 1'b0;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_done = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pick_any) nxt = LAUNCH;
      LAUNCH:  if (m.m_busy_i || tmo_hit) nxt = RUN;
      RUN:     if (!m.m_busy_i || tmo_hit) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (state == LAUNCH && tmo_hit)
      nxt = DONE;
  end

  always_comb begin
    ptr_nxt = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt_q[k])
        ptr_nxt = (k == NREQ - 1) ? 2'd0 : 2'(k + 1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      gnt_q <= '0;
      ptr   <= '0;
    end else if (state == IDLE && pick_any) begin
      gnt_q <= pick;
    end else if (state == DONE) begin
      gnt_q <= '0;
      ptr   <= ptr_nxt;
    end
  end

  // command fields follow the registered grant so they cannot change under the master
  always_comb begin
    sel_rw  = 1'b0;
    sel_ur  = 1'b0;
    sel_dev = '0;
    sel_reg = '0;
    sel_dn  = '0;
    sel_dat = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q[k] && state != IDLE) begin
        sel_rw  = sel_rw  | rw_i[k];
        sel_ur  = sel_ur  | ur_i[k];
        sel_dev = sel_dev | devadr_i[DEVADR_W*k +: DEVADR_W];
        sel_reg = sel_reg | regadr_i[REGADR_W*k +: REGADR_W];
        sel_dn  = sel_dn  | datnum_i[DATNUM_W*k +: DATNUM_W];
        sel_dat = sel_dat | wdat_i[DATA_W*k +: DATA_W];
      end
    end
  end

  always_comb begin
    m.m_enable_o = (state == LAUNCH);
    m.m_rw_o     = sel_rw;
    m.m_ur_o     = sel_ur;
    m.m_devadr_o = sel_dev;
    m.m_regadr_o = sel_reg;
    m.m_datnum_o = (state != IDLE && sel_dn == '0) ? DATNUM_W'(1) : sel_dn;
    m.m_dat_o    = sel_dat;
    m.m_reset_o  = reset_i || (state == DONE && tmo_done);
    gnt_o        = gnt_q;
    done_o       = (state == DONE) ? gnt_q : '0;
    err_o        = (state == DONE && tmo_done) ? gnt_q : '0;
    newdat_o     = gnt_q & {NREQ{m.m_newdat_i}};
    dvalid_o     = gnt_q & {NREQ{m.m_dvalid_i}};
    rdat_o       = m.m_dat_i;
  end

endmodule

// File: tb/tb_i2c_mmaster_arb.sv
// tb/tb_i2c_mmaster_arb.sv - scoreboard bench for i2c_mmaster_arb with a behavioural i2c_mmaster model
module tb_i2c_mmaster_arb;
  import i2c_arb_pkg::*;

  localparam int NREQ = 4;
  localparam logic [6:0] ABSENT = 7'h7F;
  localparam logic [6:0] STUCK  = 7'h6E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_i, rw_i, ur_i;
  logic [7*NREQ-1:0]  devadr_i;
  logic [8*NREQ-1:0]  regadr_i;
  logic [16*NREQ-1:0] datnum_i;
  logic [8*NREQ-1:0]  wdat_i;
  logic [NREQ-1:0]    gnt_o, done_o, err_o, newdat_o, dvalid_o;
  logic [7:0]         rdat_o;

  i2c_mmaster_arb_if bus();

  i2c_mmaster_arb #(.NREQ(NREQ), .TMO_CYCLES(100)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .req_i    (req_i),
    .rw_i     (rw_i),
    .ur_i     (ur_i),
    .devadr_i (devadr_i),
    .regadr_i (regadr_i),
    .datnum_i (datnum_i),
    .wdat_i   (wdat_i),
    .gnt_o    (gnt_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .newdat_o (newdat_o),
    .dvalid_o (dvalid_o),
    .rdat_o   (rdat_o),
    .m        (bus.master)
  );

  typedef struct {
    int          idx;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [15:0] dn;
    int          nd;
    int          dv;
    bit          err;
  } txn_t;

  txn_t        txq[$];
  logic [15:0] rexp[$];
  logic [7:0]  wexp[$];
  logic [7:0]  rd_mem [0:15];
  logic [7:0]  wbase  [NREQ];
  int          wpush  [NREQ];
  int          nd_seen[NREQ];
  int          done_seen[NREQ];
  int          drop_at[NREQ];
  int          checks = 0;
  int          errors = 0;

  // each requester advances its write byte on every newdat pulse it receives
  for (genvar k = 0; k < NREQ; k++) begin : g_wdat
    assign wdat_i[8*k +: 8] = wbase[k] + nd_seen[k][7:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setup_req(input int k, input bit rw, input bit ur, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [15:0] dn, input int hold);
    rw_i[k]              = rw;
    ur_i[k]              = ur;
    devadr_i[7*k +: 7]   = dev;
    regadr_i[8*k +: 8]   = rg;
    datnum_i[16*k +: 16] = dn;
    drop_at[k]           = done_seen[k] + hold;
  endtask

  task automatic expect_txn(input int k, input bit nack, input bit err);
    txn_t t;
    t.idx = k;
    t.dev = devadr_i[7*k +: 7];
    t.rg  = regadr_i[8*k +: 8];
    t.dn  = (datnum_i[16*k +: 16] == 16'd0) ? 16'd1 : datnum_i[16*k +: 16];
    t.nd  = 0;
    t.dv  = 0;
    t.err = err;
    if (!nack && !err) begin
      if (rw_i[k]) begin
        t.dv = int'(t.dn);
        for (int i = 0; i < int'(t.dn); i++) rexp.push_back({8'(k), rd_mem[i]});
      end else begin
        t.nd = int'(t.dn);
        for (int i = 0; i < int'(t.dn); i++) begin
          wexp.push_back(8'(wbase[k] + 8'(wpush[k])));
          wpush[k]++;
        end
      end
    end
    txq.push_back(t);
  endtask

  task automatic drop_finished();
    for (int k = 0; k < NREQ; k++)
      if (req_i[k] && done_seen[k] >= drop_at[k]) req_i[k] = 1'b0;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while (txq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      drop_finished();
    end
    @(negedge clk);
    drop_finished();
    check_eq({tag, "_complete"}, 32'(txq.size()), 0);
  endtask

  // behavioural i2c_mmaster: 1-cycle enable-to-busy, 3-cycle address phase, one byte strobe every 2 cycles
  int          mst = 0, mcnt = 0, mnb = 0;
  logic [6:0]  mdev;
  logic        mrw;
  logic [15:0] mdn;

  always @(negedge clk) begin
    bus.m_newdat_i = 1'b0;
    bus.m_dvalid_i = 1'b0;
    if (bus.m_reset_o) begin
      mst = 0;
      bus.m_busy_i = 1'b0;
    end else begin
      case (mst)
        0: if (bus.m_enable_o) mst = 1;
        1: begin
          bus.m_busy_i = 1'b1;
          mdev = bus.m_devadr_o;
          mrw  = bus.m_rw_o;
          mdn  = bus.m_datnum_o;
          mcnt = 0;
          mst  = 2;
        end
        2: begin
          mcnt++;
          if (mcnt == 3) begin
            mcnt = 0;
            mnb  = 0;
            mst  = (mdev == ABSENT) ? 4 : (mdev == STUCK) ? 5 : 3;
          end
        end
        3: begin
          mcnt++;
          if (mcnt[0]) begin
            if (mrw) begin
              bus.m_dat_i    = rd_mem[mnb];
              bus.m_dvalid_i = 1'b1;
            end else begin
              bus.m_newdat_i = 1'b1;
              if (wexp.size() == 0) check_eq("wr_byte_extra", 32'(wexp.size()), 1);
              else check_eq("wr_byte", 32'(bus.m_dat_o), 32'(wexp.pop_front()));
            end
            mnb++;
            if (mnb == int'(mdn)) mst = 4;
          end
        end
        4: begin
          bus.m_busy_i = 1'b0;
          mst = 0;
        end
        default: ;
      endcase
    end
  end

  logic en_prev = 1'b0;
  int   nd_cnt = 0, dv_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      nd_cnt  = 0;
      dv_cnt  = 0;
      en_prev = 1'b0;
    end else begin
      if (gnt_o != '0) check_eq("gnt_onehot", 32'($onehot(gnt_o)), 1);
      if (bus.m_enable_o && !en_prev) begin
        if (txq.size() == 0) check_eq("launch_unexp", 32'(gnt_o), 0);
        else begin
          check_eq("launch_gnt", 32'(gnt_o), 32'(1) << txq[0].idx);
          check_eq("launch_dev", 32'(bus.m_devadr_o), 32'(txq[0].dev));
          check_eq("launch_reg", 32'(bus.m_regadr_o), 32'(txq[0].rg));
          check_eq("launch_dn", 32'(bus.m_datnum_o), 32'(txq[0].dn));
        end
      end
      en_prev = bus.m_enable_o;
      if (newdat_o != '0) begin
        nd_cnt++;
        for (int k = 0; k < NREQ; k++) if (newdat_o[k]) nd_seen[k]++;
        if (txq.size() != 0) check_eq("newdat_owner", 32'(newdat_o), 32'(1) << txq[0].idx);
      end
      if (dvalid_o != '0) begin
        logic [15:0] r;
        dv_cnt++;
        if (rexp.size() == 0) check_eq("dvalid_extra", 32'(rexp.size()), 1);
        else begin
          r = rexp.pop_front();
          check_eq("dvalid_owner", 32'(dvalid_o), 32'(1) << r[15:8]);
          check_eq("rdat", 32'(rdat_o), 32'(r[7:0]));
        end
      end
      if (done_o != '0) begin
        txn_t t;
        for (int k = 0; k < NREQ; k++) if (done_o[k]) done_seen[k]++;
        if (txq.size() == 0) check_eq("done_unexp", 32'(done_o), 0);
        else begin
          t = txq.pop_front();
          check_eq("done_owner", 32'(done_o), 32'(1) << t.idx);
          check_eq("done_err", 32'(err_o), t.err ? (32'(1) << t.idx) : 32'(0));
          check_eq("done_m_reset", 32'(bus.m_reset_o), 32'(t.err));
          check_eq("done_newdat_cnt", 32'(nd_cnt), 32'(t.nd));
          check_eq("done_dvalid_cnt", 32'(dv_cnt), 32'(t.dv));
          check_eq("done_dev_held", 32'(bus.m_devadr_o), 32'(t.dev));
        end
        nd_cnt = 0;
        dv_cnt = 0;
      end else if (err_o != '0) begin
        check_eq("err_stray", 32'(err_o), 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_i = '0; rw_i = '0; ur_i = '0;
    devadr_i = '0; regadr_i = '0; datnum_i = '0;
    bus.m_busy_i = 1'b0; bus.m_dvalid_i = 1'b0; bus.m_newdat_i = 1'b0; bus.m_dat_i = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      wbase[k] = 8'(8'hC0 + 16 * k);
      wpush[k] = 0; nd_seen[k] = 0; done_seen[k] = 0; drop_at[k] = 0;
    end
    for (int i = 0; i < 16; i++) rd_mem[i] = 8'(i * 3 + 1);
    rd_mem[0] = 8'hA5; rd_mem[1] = 8'h5A; rd_mem[2] = 8'hFF;

    repeat (3) @(negedge clk);
    check_eq("rst_m_reset", 32'(bus.m_reset_o), 1);
    check_eq("rst_gnt", 32'(gnt_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_enable", 32'(bus.m_enable_o), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_m_reset", 32'(bus.m_reset_o), 0);
    check_eq("idle_dev", 32'(bus.m_devadr_o), 0);
    check_eq("idle_dn", 32'(bus.m_datnum_o), 0);

    // single write with launch timing
    setup_req(0, 1'b0, 1'b1, 7'h50, 8'h10, 16'd2, 1);
    expect_txn(0, 1'b0, 1'b0);
    req_i[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("t1_gnt", 32'(gnt_o), 1);
    check_eq("t1_enable", 32'(bus.m_enable_o), 1);
    @(posedge clk); #1;
    check_eq("t2_enable", 32'(bus.m_enable_o), 1);
    @(posedge clk); #1;
    check_eq("t3_enable", 32'(bus.m_enable_o), 0);
    check_eq("run_ur", 32'(bus.m_ur_o), 1);
    check_eq("run_rw", 32'(bus.m_rw_o), 0);
    run_until_empty("write", 200);

    // read path on requester 1
    setup_req(1, 1'b1, 1'b0, 7'h21, 8'h04, 16'd3, 1);
    expect_txn(1, 1'b0, 1'b0);
    req_i[1] = 1'b1;
    run_until_empty("read", 200);

    // ptr is now 2: req 0011 must go to requester 0, then 1, then 0 again
    setup_req(0, 1'b0, 1'b0, 7'h33, 8'h00, 16'd0, 2);
    setup_req(1, 1'b1, 1'b1, 7'h34, 8'h20, 16'd1, 1);
    expect_txn(0, 1'b0, 1'b0);
    expect_txn(1, 1'b0, 1'b0);
    expect_txn(0, 1'b0, 1'b0);
    req_i[0] = 1'b1;
    req_i[1] = 1'b1;
    run_until_empty("contend", 400);

    // NACK then a normal transaction
    setup_req(3, 1'b0, 1'b1, ABSENT, 8'h01, 16'd4, 1);
    expect_txn(3, 1'b1, 1'b0);
    req_i[3] = 1'b1;
    run_until_empty("nack", 200);
    setup_req(2, 1'b0, 1'b1, 7'h44, 8'h02, 16'd1, 1);
    expect_txn(2, 1'b0, 1'b0);
    req_i[2] = 1'b1;
    run_until_empty("after_nack", 200);

    // reset while RUN; ptr is 3 here, so a post-reset 1010 request exposes a stale ptr
    setup_req(2, 1'b0, 1'b0, 7'h45, 8'h03, 16'd10, 1);
    expect_txn(2, 1'b0, 1'b0);
    req_i[2] = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("pre_rst_gnt", 32'(gnt_o), 4);
    rst = 1'b1;
    req_i[2] = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_gnt", 32'(gnt_o), 0);
    check_eq("mid_rst_done", 32'(done_o), 0);
    check_eq("mid_rst_enable", 32'(bus.m_enable_o), 0);
    check_eq("mid_rst_dev", 32'(bus.m_devadr_o), 0);
    check_eq("mid_rst_newdat", 32'(newdat_o), 0);
    check_eq("mid_rst_m_reset", 32'(bus.m_reset_o), 1);
    txq.delete();
    wexp.delete();
    rexp.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    setup_req(1, 1'b1, 1'b0, 7'h61, 8'h05, 16'd2, 1);
    setup_req(3, 1'b0, 1'b0, 7'h63, 8'h06, 16'd1, 1);
    expect_txn(1, 1'b0, 1'b0);
    expect_txn(3, 1'b0, 1'b0);
    req_i[1] = 1'b1;
    req_i[3] = 1'b1;
    run_until_empty("post_rst", 400);

`ifdef I2C_ARB_TIMEOUT_EN
    // stuck slave on requester 0 times out, then requester 1 is served
    setup_req(0, 1'b0, 1'b0, STUCK, 8'h07, 16'd1, 1);
    setup_req(1, 1'b0, 1'b0, 7'h52, 8'h08, 16'd1, 1);
    expect_txn(0, 1'b0, 1'b1);
    expect_txn(1, 1'b0, 1'b0);
    req_i[0] = 1'b1;
    req_i[1] = 1'b1;
    run_until_empty("timeout", 600);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
